rtc_access_ctrl: RTL and testbench

- Wishbone master that sequences multi-word accesses to the system-config RTC registers (TIME_SEC_2/1/0, TIME_TICKER) on behalf of one local requester.
- Set: three ordered writes with SEC_0 last, since the SEC_0 write triggers the RTC load.
- Get: reads a coherent 48-bit seconds value plus ticker, retrying if SEC_0 changes mid-sequence.
- Sits between the monitor controller logic and the wishbone interconnect port of the system-config slave.

---
 rtl/rtc_access_ctrl_if.sv | 20 ++
 rtl/rtc_access_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_rtc_access_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/rtc_access_ctrl_if.sv
// rtl/rtc_access_ctrl_if.sv - wishbone master port bundle for the RTC access sequencer
interface rtc_access_ctrl_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [15:0] wbm_adr_o;
  logic [15:0] wbm_dat_o;
  logic [15:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/rtc_access_ctrl.sv
// rtl/rtc_access_ctrl.sv - sequences ordered RTC set writes and coherent RTC get reads
module rtc_access_ctrl #(
  parameter logic [15:0] ADR_SEC_2  = 16'd6,
  parameter logic [15:0] ADR_SEC_1  = 16'd7,
  parameter logic [15:0] ADR_SEC_0  = 16'd8,
  parameter logic [15:0] ADR_TICKER = 16'd9,
  parameter int          TIMEOUT    = 255,
  parameter int          MAX_RETRY  = 3
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  rtc_access_ctrl_if.master        wbm,
  input  logic                     set_req,
  input  logic [47:0]              set_time,
  input  logic                     get_req,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [47:0]              time_o,
  output logic [14:0]              ticker_o
);

  typedef enum logic [3:0] {IDLE, W2, W1, W0, RA, R2, R1, RB, RT, FIN} state_t;

  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

  state_t      state_q, state_d;
  logic        stb_q, stb_d, we_q, we_d;
  logic [15:0] adr_q, adr_d, dat_q, dat_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [3:0]  retry_q, retry_d;
  logic        pend_q, pend_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [47:0] set_q, set_d, time_q, time_d;
  logic [15:0] a_q, a_d, s2_q, s2_d, s1_q, s1_d, b_q, b_d;
  logic [14:0] tick_q, tick_d;
  logic        start;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      tmo_q   <= '0;
      retry_q <= '0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      set_q   <= '0;
      time_q  <= '0;
      tick_q  <= '0;
      a_q     <= '0;
      s2_q    <= '0;
      s1_q    <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      tmo_q   <= tmo_d;
      retry_q <= retry_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      set_q   <= set_d;
      time_q  <= time_d;
      tick_q  <= tick_d;
      a_q     <= a_d;
      s2_q    <= s2_d;
      s1_q    <= s1_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    tmo_d   = tmo_q;
    retry_d = retry_q;
    pend_d  = pend_q;
    set_d   = set_q;
    time_d  = time_q;
    tick_d  = tick_q;
    a_d     = a_q;
    s2_d    = s2_q;
    s1_d    = s1_q;
    b_d     = b_q;
    err_d   = 1'b0;
    start   = 1'b0;

    case (state_q)
      IDLE: begin
        if (set_req) begin
          set_d   = set_time;
          pend_d  = get_req;
          state_d = W2;
          start   = 1'b1;
        end else if (get_req || pend_q) begin
          pend_d  = 1'b0;
          state_d = RA;
          start   = 1'b1;
        end
      end
      FIN: begin
        retry_d = '0;
        if (pend_q) begin
          pend_d  = 1'b0;
          state_d = RA;
          start   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        if ((state_q == W2 || state_q == W1 || state_q == W0) && get_req)
          pend_d = 1'b1;
        // stb low inside an access state is the idle gap after the previous ack
        if (!stb_q) begin
          start = 1'b1;
        end else if (wbm.wbm_ack_i) begin
          stb_d = 1'b0;
          case (state_q)
            W2: state_d = W1;
            W1: state_d = W0;
            W0: state_d = FIN;
            RA: begin a_d = wbm.wbm_dat_i; state_d = R2; end
            R2: begin s2_d = wbm.wbm_dat_i; state_d = R1; end
            R1: begin s1_d = wbm.wbm_dat_i; state_d = RB; end
            RB: begin
              if (wbm.wbm_dat_i == a_q) begin
                b_d     = wbm.wbm_dat_i;
                state_d = RT;
              end else if (retry_q >= RETRY_MAX) begin
                err_d   = 1'b1;
                state_d = FIN;
              end else begin
                retry_d = retry_q + 4'd1;
                state_d = RA;
              end
            end
            RT: begin
              time_d  = {s2_q, s1_q, b_q};
              tick_d  = wbm.wbm_dat_i[14:0];
              state_d = FIN;
            end
            default: state_d = IDLE;
          endcase
        end else if (tmo_q == TMO_LAST) begin
          stb_d   = 1'b0;
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
    endcase

    if (start) begin
      stb_d = 1'b1;
      tmo_d = '0;
      we_d  = 1'b0;
      dat_d = '0;
      case (state_d)
        W2:      begin we_d = 1'b1; adr_d = ADR_SEC_2; dat_d = set_d[47:32]; end
        W1:      begin we_d = 1'b1; adr_d = ADR_SEC_1; dat_d = set_d[31:16]; end
        W0:      begin we_d = 1'b1; adr_d = ADR_SEC_0; dat_d = set_d[15:0];  end
        R2:      adr_d = ADR_SEC_2;
        R1:      adr_d = ADR_SEC_1;
        RT:      adr_d = ADR_TICKER;
        default: adr_d = ADR_SEC_0;
      endcase
    end

    done_d = (state_d == FIN);
    busy_d = (state_d != IDLE) || pend_d;
  end

  assign wbm.wbm_cyc_o = stb_q;
  assign wbm.wbm_stb_o = stb_q;
  assign wbm.wbm_we_o  = we_q;
  assign wbm.wbm_adr_o = adr_q;
  assign wbm.wbm_dat_o = dat_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign time_o        = time_q;
  assign ticker_o      = tick_q;

endmodule

// File: tb/tb_rtc_access_ctrl.sv
// tb/tb_rtc_access_ctrl.sv - directed bench for rtc_access_ctrl against a wishbone slave model
module tb_rtc_access_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        set_req = 1'b0;
  logic        get_req = 1'b0;
  logic [47:0] set_time = '0;
  logic        busy, done, err;
  logic [47:0] time_o;
  logic [14:0] ticker_o;

  rtc_access_ctrl_if wb();

  rtc_access_ctrl dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbm      (wb),
    .set_req  (set_req),
    .set_time (set_time),
    .get_req  (get_req),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .time_o   (time_o),
    .ticker_o (ticker_o)
  );

  always #5 clk = ~clk;

  // slave model: acks the cycle after stb, registers 6..9, optional SEC_0/SEC_1 change after first SEC_0 read
  logic [15:0] sec2 = 16'h0, sec1 = 16'h0, sec0 = 16'h0, tick = 16'h0;
  logic        ack_en = 1'b1;
  logic        flip_arm = 1'b0;
  logic        ack = 1'b0;
  logic [15:0] rdat = 16'h0;
  logic [32:0] log_q[$];

  assign wb.wbm_ack_i = ack;
  assign wb.wbm_dat_i = rdat;

  always @(posedge clk) begin
    if (wb.wbm_cyc_o && wb.wbm_stb_o && !ack && ack_en) begin
      ack <= 1'b1;
      if (wb.wbm_we_o) begin
        log_q.push_back({1'b1, wb.wbm_adr_o, wb.wbm_dat_o});
        case (wb.wbm_adr_o)
          16'd6: sec2 = wb.wbm_dat_o;
          16'd7: sec1 = wb.wbm_dat_o;
          16'd8: sec0 = wb.wbm_dat_o;
          16'd9: tick = wb.wbm_dat_o;
          default: ;
        endcase
      end else begin
        log_q.push_back({1'b0, wb.wbm_adr_o, 16'h0});
        case (wb.wbm_adr_o)
          16'd6: rdat <= sec2;
          16'd7: rdat <= sec1;
          16'd8: rdat <= sec0;
          16'd9: rdat <= tick;
          default: rdat <= 16'hDEAD;
        endcase
        if (wb.wbm_adr_o == 16'd8 && flip_arm) begin
          flip_arm = 1'b0;
          sec0 = 16'h0000;
          sec1 = 16'h0002;
        end
      end
    end else begin
      ack <= 1'b0;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int   n_last, n_dones, stb_cyc;
  logic err_seen, busy_gap;

  // issue a request at a negedge (cycle 0) and watch until want_dones done pulses or max_cyc
  task automatic run(input logic s, input logic g, input logic [47:0] t, input int want_dones,
                     input int max_cyc);
    int n;
    n = 0;
    n_last = 0; n_dones = 0; stb_cyc = 0; err_seen = 1'b0; busy_gap = 1'b0;
    log_q.delete();
    @(negedge clk);
    set_req = s; get_req = g; set_time = t;
    while (n_dones < want_dones && n < max_cyc) begin
      @(posedge clk);
      #1 set_req = 1'b0; get_req = 1'b0;
      @(negedge clk);
      n++;
      if (wb.wbm_stb_o) stb_cyc++;
      if (err) err_seen = 1'b1;
      if (done) begin n_dones++; n_last = n; end
      if (!busy) busy_gap = 1'b1;
    end
    check("done_count", 64'(n_dones), 64'(want_dones));
  endtask

  task automatic check_log(input string tag, input logic [32:0] exp[$]);
    check({tag, "_len"}, 64'(log_q.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < log_q.size(); i++)
      check($sformatf("%s_%0d", tag, i), 64'(log_q[i]), 64'(exp[i]));
  endtask

  initial begin
    logic [32:0] exp_log[$];
    int k;

    repeat (3) @(negedge clk);
    check("rst_cyc", 64'(wb.wbm_cyc_o), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_time", 64'(time_o), 64'd0);
    check("idle_err", 64'(err), 64'd0);

    // set sequence
    run(1'b1, 1'b0, 48'h0000_5F5E_1000, 1, 100);
    exp_log = '{{1'b1, 16'd6, 16'h0000}, {1'b1, 16'd7, 16'h5F5E}, {1'b1, 16'd8, 16'h1000}};
    check_log("set_wr", exp_log);
    check("set_lat", 64'(n_last), 64'd9);
    check("set_err", 64'(err_seen), 64'd0);
    check("set_time_o", 64'(time_o), 64'd0);

    // clean get
    tick = 16'h1234;
    run(1'b0, 1'b1, '0, 1, 100);
    exp_log = '{{1'b0, 16'd8, 16'h0}, {1'b0, 16'd6, 16'h0}, {1'b0, 16'd7, 16'h0},
                {1'b0, 16'd8, 16'h0}, {1'b0, 16'd9, 16'h0}};
    check_log("get_rd", exp_log);
    check("get_lat", 64'(n_last), 64'd15);
    check("get_err", 64'(err_seen), 64'd0);
    check("get_time", 64'(time_o), 64'h0000_5F5E_1000);
    check("get_tick", 64'(ticker_o), 64'h1234);

    // SEC_0 rolls FFFF->0000 between RA and RB: one retry
    sec2 = 16'h0000; sec1 = 16'h0001; sec0 = 16'hFFFF; tick = 16'h0321;
    flip_arm = 1'b1;
    run(1'b0, 1'b1, '0, 1, 100);
    check("retry_reads", 64'(log_q.size()), 64'd9);
    check("retry_lat", 64'(n_last), 64'd27);
    check("retry_err", 64'(err_seen), 64'd0);
    check("retry_time", 64'(time_o), 64'h0000_0002_0000);
    check("retry_tick", 64'(ticker_o), 64'h0321);

    // slave never acks
    ack_en = 1'b0;
    run(1'b0, 1'b1, '0, 1, 400);
    check("tmo_stb_cycles", 64'(stb_cyc), 64'd255);
    check("tmo_err", 64'(err_seen), 64'd1);
    check("tmo_time", 64'(time_o), 64'h0000_0002_0000);
    check("tmo_tick", 64'(ticker_o), 64'h0321);
    ack_en = 1'b1;
    tick = 16'h0042;
    run(1'b0, 1'b1, '0, 1, 100);
    check("post_tmo_err", 64'(err_seen), 64'd0);
    check("post_tmo_tick", 64'(ticker_o), 64'h0042);

    // set and get together: set first, get pending, two done pulses
    tick = 16'h7FFF;
    run(1'b1, 1'b1, 48'hABCD_1234_5678, 2, 100);
    exp_log = '{{1'b1, 16'd6, 16'hABCD}, {1'b1, 16'd7, 16'h1234}, {1'b1, 16'd8, 16'h5678},
                {1'b0, 16'd8, 16'h0}, {1'b0, 16'd6, 16'h0}, {1'b0, 16'd7, 16'h0},
                {1'b0, 16'd8, 16'h0}, {1'b0, 16'd9, 16'h0}};
    check_log("both", exp_log);
    check("both_lat", 64'(n_last), 64'd24);
    check("both_busy_gap", 64'(busy_gap), 64'd0);
    check("both_err", 64'(err_seen), 64'd0);
    check("both_time", 64'(time_o), 64'hABCD_1234_5678);
    check("both_tick", 64'(ticker_o), 64'h7FFF);

    // reset mid-W1
    log_q.delete();
    @(negedge clk);
    set_req = 1'b1; set_time = 48'h1111_2222_3333;
    @(posedge clk);
    #1 set_req = 1'b0;
    k = 0;
    while (!(wb.wbm_stb_o && wb.wbm_adr_o == 16'd7) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("w1_reached", 64'(k < 50), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_cyc", 64'(wb.wbm_cyc_o), 64'd0);
    check("arst_stb", 64'(wb.wbm_stb_o), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_busy", 64'(busy), 64'd0);
      check("post_rst_done", 64'(done), 64'd0);
    end
    check("post_rst_time", 64'(time_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
